// File: rtl/dct_quant_zigzag_if.sv
`default_nettype none
// ============================================================================
//  Module      : dct_quant_zigzag_if
//  Description : Coefficient write port plus quantized zigzag output stream
//                of the DCT quantizer stage, with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dct_quant_zigzag_if #(
    parameter int DW = 8
);
    logic          wea;
    logic [6:0]    ram_dct_add;
    logic [DW-1:0] data_in;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          ovf;

    // Producer/consumer side: drives writes and accepts the stream
    modport master (
        output wea, ram_dct_add, data_in, out_ready,
        input  in_ready, out_data, out_valid, out_last, ovf
    );

    // Quantizer side
    modport slave (
        input  wea, ram_dct_add, data_in, out_ready,
        output in_ready, out_data, out_valid, out_last, ovf
    );
endinterface
`default_nettype wire

// File: rtl/dct_quant_zigzag.sv
`default_nettype none
// ============================================================================
//  Module      : dct_quant_zigzag
//  Description : Ping-pong 8x8 coefficient buffer, reciprocal-multiply JPEG
//                luminance quantizer and zigzag-order streaming output.
//  Revision    : 1.0 - initial release
// ============================================================================
module dct_quant_zigzag #(
    parameter int DW  = 8,
    parameter int RW  = 16,
    parameter int RND = 1
) (
    input  logic             clk,
    input  logic             reset,
    dct_quant_zigzag_if.slave bus
);
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_STREAM = 1'b1;
    localparam int         c_PW     = DW + 1 + RW;

    // Zigzag scan order, entry 0 in the most significant slot
    localparam logic [64*6-1:0] c_ZZ = {
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

    // JPEG luminance quantizer in raster order, entry 0 most significant
    localparam logic [64*7-1:0] c_QTAB = {
        7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61,
        7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55,
        7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56,
        7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62,
        7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77,
        7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92,
        7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
        7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99};

    localparam logic [c_PW-1:0] c_ROUND = (RND != 0) ? (c_PW'(1) << (RW - 1)) : '0;

    logic [DW-1:0] r_mem [2][64];
    logic [1:0]    r_full;
    logic          r_wptr;
    logic          r_rptr;
    logic          r_ovf;
    logic [0:0]    r_state;
    logic [5:0]    r_cnt;

    logic          r_s1_valid, r_s1_last;
    logic [DW-1:0] r_s1_coef;
    logic [RW-1:0] r_s1_recip;
    logic          r_s2_valid, r_s2_last, r_s2_neg;
    logic [c_PW-1:0] r_s2_m;
    logic          r_out_valid, r_out_last;
    logic [DW-1:0] r_out_data;

    logic [RW-1:0] w_recip_rom [64];
    logic          w_adv, w_wr_ok, w_wr_last, w_issue, w_issue_last;
    logic [5:0]    w_rev, w_zz;
    logic [DW:0]   w_mag, w_qmag;
    logic [c_PW-1:0] w_prod;
    logic [DW-1:0] w_q;
    logic          w_unused;

    // Reciprocals are elaboration-time constants, so this folds into a ROM
    for (genvar k = 0; k < 64; k++) begin : g_recip
        assign w_recip_rom[k] = RW'((64'd1 << RW) / 64'(c_QTAB[(63 - k) * 7 +: 7]));
    end

    assign w_unused     = bus.ram_dct_add[6];
    assign w_adv        = !r_out_valid || bus.out_ready;
    assign w_wr_ok      = bus.wea && !r_full[r_wptr];
    assign w_wr_last    = w_wr_ok && (bus.ram_dct_add[5:0] == 6'd63);
    // IDLE with a full bank issues index 0 at once so the first result is 3 edges out
    assign w_issue      = w_adv && ((r_state == c_STREAM) || r_full[r_rptr]);
    assign w_issue_last = w_issue && (r_cnt == 6'd63);
    assign w_rev        = 6'd63 - r_cnt;
    assign w_zz         = c_ZZ[w_rev * 6 +: 6];

    assign w_mag  = r_s1_coef[DW-1] ? (~{1'b1, r_s1_coef} + 1'b1) : {1'b0, r_s1_coef};
    assign w_prod = c_PW'(w_mag) * c_PW'(r_s1_recip) + c_ROUND;
    assign w_qmag = r_s2_m[c_PW-1:RW];
    // Negating a zero magnitude yields zero, so no negative zero can appear
    assign w_q    = r_s2_neg ? DW'(~w_qmag + 1'b1) : DW'(w_qmag);

    assign bus.in_ready  = !r_full[r_wptr];
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.ovf       = r_ovf;

    // Coefficient storage for the current write bank
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr][bus.ram_dct_add[5:0]] <= bus.data_in;
        end
    end

    // Bank bookkeeping, overflow flag and read sequencer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full  <= 2'b00;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= c_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            if (w_wr_last) begin
                r_full[r_wptr] <= 1'b1;
                r_wptr         <= ~r_wptr;
            end
            // Placed after the set so a clear of the same bank takes priority
            if (w_issue_last) begin
                r_full[r_rptr] <= 1'b0;
                r_rptr         <= ~r_rptr;
            end
            if (bus.wea && r_full[r_wptr]) begin
                r_ovf <= 1'b1;
            end
            if (w_issue) begin
                if (r_cnt == 6'd63) begin
                    r_state <= c_IDLE;
                    r_cnt   <= 6'd0;
                end else begin
                    r_state <= c_STREAM;
                    r_cnt   <= r_cnt + 6'd1;
                end
            end
        end
    end

    // Datapath registers of stages 1 and 2, frozen while the output stalls
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_coef  <= r_mem[r_rptr][w_zz];
            r_s1_recip <= w_recip_rom[w_zz];
            r_s2_neg   <= r_s1_coef[DW-1];
            r_s2_m     <= w_prod;
        end
    end

    // Pipeline valid/last tracking and the registered output stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= w_issue;
            r_s1_last   <= w_issue_last;
            r_s2_valid  <= r_s1_valid;
            r_s2_last   <= r_s1_last;
            r_out_valid <= r_s2_valid;
            r_out_last  <= r_s2_valid && r_s2_last;
            if (r_s2_valid) begin
                r_out_data <= w_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dct_quant_zigzag.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dct_quant_zigzag
//  Description : Directed bench with a zigzag/quantizer reference model and
//                a per-transfer compare process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_quant_zigzag;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dct_quant_zigzag_if #(.DW(8)) bus ();
    dct_quant_zigzag_if #(.DW(8)) bus_t ();

    dct_quant_zigzag #(.DW(8), .RW(16), .RND(1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    dct_quant_zigzag #(.DW(8), .RW(16), .RND(0)) u_dut_trunc (
        .clk(clk), .reset(reset), .bus(bus_t));

    assign bus_t.wea         = bus.wea;
    assign bus_t.ram_dct_add = bus.ram_dct_add;
    assign bus_t.data_in     = bus.data_in;
    assign bus_t.out_ready   = bus.out_ready;

    typedef struct {
        logic [7:0] d_rnd;
        logic [7:0] d_trn;
        logic       last;
        int         idx;
    } exp_t;

    int QTAB[64] = '{16, 11, 10, 16, 24, 40, 51, 61,
                     12, 12, 14, 19, 26, 58, 60, 55,
                     14, 13, 16, 24, 40, 57, 69, 56,
                     14, 17, 22, 29, 51, 87, 80, 62,
                     18, 22, 37, 56, 68, 109, 103, 77,
                     24, 35, 55, 64, 81, 104, 113, 92,
                     49, 64, 78, 87, 103, 121, 120, 101,
                     72, 92, 95, 98, 112, 100, 103, 99};
    int ZZ[64];
    int cur_blk[64];
    exp_t exp_q[$];
    exp_t e_cmp;
    logic [7:0] log_rnd[$];
    logic [7:0] log_trn[$];
    int n_out = 0;
    int n_checks = 0;
    int n_errors = 0;

    // Reference quantizer: sign-magnitude reciprocal multiply
    function automatic int quant(input int c, input int q, input int rnd);
        int mag, m, qm;
        mag = (c < 0) ? -c : c;
        m   = mag * (65536 / q) + ((rnd != 0) ? 32768 : 0);
        qm  = m >>> 16;
        return (c < 0) ? -qm : qm;
    endfunction

    // Zigzag scan built by walking anti-diagonals of the 8x8 block
    task automatic build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin ZZ[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin ZZ[k] = r * 8 + (s - r); k++; end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic write_word(input int a, input int d);
        bus.wea         = 1'b1;
        bus.ram_dct_add = {1'($urandom_range(0, 1)), 6'(a)};
        bus.data_in     = 8'(d);
        @(posedge clk);
        #1;
        bus.wea = 1'b0;
    endtask

    task automatic write_block(input bit accept);
        exp_t e;
        for (int k = 0; k < 64; k++) write_word(k, cur_blk[k]);
        if (accept) begin
            for (int k = 0; k < 64; k++) begin
                e.d_rnd = 8'(quant(cur_blk[ZZ[k]], QTAB[ZZ[k]], 1));
                e.d_trn = 8'(quant(cur_blk[ZZ[k]], QTAB[ZZ[k]], 0));
                e.last  = (k == 63);
                e.idx   = k;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic clear_blk();
        for (int k = 0; k < 64; k++) cur_blk[k] = 0;
    endtask

    task automatic wait_outs(input int n);
        for (int c = 0; c < 4000 && n_out < n; c++) @(posedge clk);
        n_checks++;
        if (n_out < n) begin
            n_errors++;
            $display("FAIL wait_outputs got=%0d expected=%0d", n_out, n);
        end
        #1;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(posedge clk);
        chk("drain_pending", exp_q.size(), 0);
        #1;
    endtask

    // Compare process: every accepted transfer against the model queue
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid && bus.out_ready) begin
                log_rnd.push_back(bus.out_data);
                log_trn.push_back(bus_t.out_data);
                n_out++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_output got=%0h expected=none", bus.out_data);
                end else begin
                    e_cmp = exp_q.pop_front();
                    if (bus.out_data !== e_cmp.d_rnd || bus.out_last !== e_cmp.last ||
                        bus_t.out_valid !== 1'b1 || bus_t.out_data !== e_cmp.d_trn ||
                        bus_t.out_last !== e_cmp.last) begin
                        n_errors++;
                        $display("FAIL stream k=%0d got=%0h/%0b trunc=%0h/%0b/%0b expected=%0h/%0b trunc=%0h",
                                 e_cmp.idx, bus.out_data, bus.out_last, bus_t.out_data,
                                 bus_t.out_last, bus_t.out_valid, e_cmp.d_rnd, e_cmp.last, e_cmp.d_trn);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nz, cyc;
        logic [7:0] held;
        logic held_last;
        build_zz();
        bus.wea = 1'b0; bus.ram_dct_add = '0; bus.data_in = '0; bus.out_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1 reset = 1'b1;

        // Model pins
        chk("model_zz2", ZZ[2], 8);
        chk("model_zz5", ZZ[5], 2);
        chk("model_zz62", ZZ[62], 62);
        chk("model_q_p100", quant(100, 16, 1), 6);
        chk("model_q_m100_trn", 32'(quant(-100, 16, 0)), 32'(-6));
        chk("model_q_m128", 32'(quant(-128, 16, 1)), 32'(-8));
        chk("model_q_120", quant(120, 12, 1), 10);

        // T1: single DC coefficient, latency and count
        clear_blk(); cur_blk[0] = 100;
        base = n_out;
        write_block(1);
        @(negedge clk); chk("t1_lat0", bus.out_valid, 0);
        @(negedge clk); chk("t1_lat1", bus.out_valid, 0);
        @(negedge clk); chk("t1_lat2", bus.out_valid, 0);
        @(negedge clk); chk("t1_lat3", bus.out_valid, 1);
        wait_drain();
        chk("t1_count", n_out - base, 64);
        chk("t1_first", log_rnd[base], 8'd6);
        nz = 0;
        for (int k = 1; k < 64; k++) if (log_rnd[base + k] != 8'd0) nz++;
        chk("t1_zeros", nz, 0);

        // T2: negative values, both rounding modes, back-to-back blocks
        base = n_out;
        cur_blk[0] = -100; write_block(1);
        cur_blk[0] = -128; write_block(1);
        wait_drain();
        chk("t2_m100_rnd", log_rnd[base], 8'hFA);
        chk("t2_m100_trn", log_trn[base], 8'hFA);
        chk("t2_m128_rnd", log_rnd[base + 64], 8'hF8);
        chk("t2_m128_trn", log_trn[base + 64], 8'hF8);

        // T3: zigzag placement
        clear_blk();
        cur_blk[8] = 120; cur_blk[1] = 55; cur_blk[63] = -77; cur_blk[27] = 127; cur_blk[36] = -1;
        base = n_out;
        write_block(1);
        wait_drain();
        chk("t3_idx1", log_rnd[base + 1], 8'd5);
        chk("t3_idx2", log_rnd[base + 2], 8'd10);

        // T4: output stall mid-block
        for (int k = 0; k < 64; k++) cur_blk[k] = (k * 37) % 256 - 128;
        base = n_out;
        write_block(1);
        wait_outs(base + 20);
        bus.out_ready = 1'b0;
        @(negedge clk);
        held = bus.out_data; held_last = bus.out_last;
        chk("t4_valid_held", bus.out_valid, 1);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("t4_stall_data", bus.out_data, held);
            chk("t4_stall_last", bus.out_last, held_last);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_drain();
        chk("t4_count", n_out - base, 64);

        // T5: both banks full, third block dropped, A/B back-to-back
        chk("t5_ovf_before", bus.ovf, 0);
        bus.out_ready = 1'b0;
        base = n_out;
        for (int k = 0; k < 64; k++) cur_blk[k] = k - 32;
        write_block(1);
        for (int k = 0; k < 64; k++) cur_blk[k] = 31 - 2 * k;
        write_block(1);
        @(negedge clk); chk("t5_in_ready_low", bus.in_ready, 0);
        for (int k = 0; k < 64; k++) cur_blk[k] = 50;
        write_block(0);
        @(negedge clk); chk("t5_ovf_set", bus.ovf, 1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        cyc = 0;
        while (n_out < base + 128 && cyc < 1000) begin @(posedge clk); cyc++; end
        chk("t5_no_gap_cycles", cyc, 128);
        wait_drain();
        repeat (80) @(posedge clk);
        #1;
        chk("t5_count", n_out - base, 128);

        // T6: reset mid-block, then a fresh block
        for (int k = 0; k < 64; k++) cur_blk[k] = (k % 7) * 10 - 30;
        base = n_out;
        write_block(1);
        wait_outs(base + 30);
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_out_data", bus.out_data, 0);
        chk("t6_ovf", bus.ovf, 0);
        chk("t6_in_ready", bus.in_ready, 1);
        for (int k = 0; k < 64; k++) cur_blk[k] = (k * 13) % 200 - 100;
        base = n_out;
        write_block(1);
        wait_drain();
        repeat (10) @(posedge clk);
        #1;
        chk("t6_count", n_out - base, 64);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
